regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/regfile_arbiter_rr_pick.sv | 30 +++
 rtl/regfile_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizing for the register-file arbiter.
package rf_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEFAULT        = 8;
    localparam int NREQ_DEFAULT     = 3;
    localparam int LOCK_MAX_DEFAULT = 16;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   win_o,
    output logic            any_o
);

    int          j;
    logic [IW-1:0] jw;

    always_comb begin
        any_o = 1'b0;
        win_o = '0;
        j     = 0;
        jw    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(ptr_i) + k) % NREQ;
            jw = IW'(j);
            if (!any_o && req_i[jw]) begin
                any_o = 1'b1;
                win_o = jw;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port among NREQ requesters.
// Optional bus lock selected by `define RF_ARB_LOCK_EN.
module regfile_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int NREQ     = NREQ_DEFAULT,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [3*NREQ-1:0] sel,
    input  logic [N*NREQ-1:0] wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [N-1:0]      rdata,
    output logic              rf_write_en,
    output logic              rf_out_en,
    output logic [2:0]        rf_sel,
    output logic [N-1:0]      rf_data_in,
    input  logic [N-1:0]      rf_data_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic          rf_write_en_q, rf_write_en_d;
    logic          rf_out_en_q, rf_out_en_d;
    logic [2:0]    rf_sel_q, rf_sel_d;
    logic [N-1:0]  rf_data_in_q, rf_data_in_d;

    logic [2:0]    sel_a   [NREQ];
    logic [N-1:0]  wdata_a [NREQ];
    logic [IW-1:0] rr_win, arb_win;
    logic          rr_any, arb_any, lock_force;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign sel_a[i]   = sel[3*i +: 3];
        assign wdata_a[i] = wdata[N*i +: N];
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .win_o (rr_win),
        .any_o (rr_any)
    );

`ifdef RF_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    // The first grant of a run comes from round-robin, so LOCK_MAX-1 forced re-grants cap the run.
    assign lock_force = (state_q == GRANT) && lock[win_q] && req[win_q] &&
                        (lock_cnt_q < CW'(LOCK_MAX - 1));
    assign lock_cnt_d = lock_force ? lock_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_cnt_q <= '0;
        else        lock_cnt_q <= lock_cnt_d;
    end
`else
    assign lock_force = 1'b0;
`endif

    assign arb_win = lock_force ? win_q : rr_win;
    assign arb_any = lock_force | rr_any;

    always_comb begin
        state_d       = arb_any ? GRANT : IDLE;
        win_d         = win_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = '0;
        rvalid_d      = '0;
        rdata_d       = rdata_q;
        rf_write_en_d = 1'b0;
        rf_out_en_d   = 1'b0;
        rf_sel_d      = rf_sel_q;
        rf_data_in_d  = rf_data_in_q;
        if (state_q == GRANT && rf_out_en_q) begin
            rdata_d  = rf_data_out;
            rvalid_d = NREQ'(1) << win_q;
        end
        // Every GRANT cycle is also an arbitration point, giving one access per cycle.
        if (arb_any) begin
            win_d         = arb_win;
            rr_ptr_d      = (arb_win == IW'(NREQ - 1)) ? '0 : arb_win + 1'b1;
            gnt_d         = NREQ'(1) << arb_win;
            rf_write_en_d = we[arb_win];
            rf_out_en_d   = !we[arb_win];
            rf_sel_d      = sel_a[arb_win];
            rf_data_in_d  = wdata_a[arb_win];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_q         <= '0;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            rf_write_en_q <= 1'b0;
            rf_out_en_q   <= 1'b0;
            rf_sel_q      <= '0;
            rf_data_in_q  <= '0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rf_write_en_q <= rf_write_en_d;
            rf_out_en_q   <= rf_out_en_d;
            rf_sel_q      <= rf_sel_d;
            rf_data_in_q  <= rf_data_in_d;
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rf_write_en = rf_write_en_q;
    assign rf_out_en   = rf_out_en_q;
    assign rf_sel      = rf_sel_q;
    assign rf_data_in  = rf_data_in_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural 8-entry register file.
module tb_regfile_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req   = '0;
    logic [2:0]  we    = '0;
    logic [8:0]  sel   = '0;
    logic [23:0] wdata = '0;
`ifdef RF_ARB_LOCK_EN
    logic [2:0]  lock  = '0;
`endif
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata, rf_data_in, rf_data_out;
    logic        rf_write_en, rf_out_en;
    logic [2:0]  rf_sel;

    regfile_arbiter #(.N(8), .NREQ(3), .LOCK_MAX(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .sel         (sel),
        .wdata       (wdata),
`ifdef RF_ARB_LOCK_EN
        .lock        (lock),
`endif
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rf_write_en (rf_write_en),
        .rf_out_en   (rf_out_en),
        .rf_sel      (rf_sel),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    always @(posedge clk) if (rf_write_en) mem[rf_sel] <= rf_data_in;
    assign rf_data_out = mem[rf_sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int c; int idx; bit wr; logic [2:0] s; logic [7:0] d; } gexp_t;
    typedef struct { int c; int idx; logic [7:0] d; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a grant or read data.
    gexp_t g;
    rexp_t r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 3'b000) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_vec",   32'(gnt), 32'(1) << g.idx);
                    chk("gnt_cycle", 32'(cyc), 32'(g.c));
                    chk("gnt_we",    32'(rf_write_en), 32'(g.wr));
                    chk("gnt_oe",    32'(rf_out_en), 32'(!g.wr));
                    chk("gnt_sel",   32'(rf_sel), 32'(g.s));
                    if (g.wr) chk("gnt_wdata", 32'(rf_data_in), 32'(g.d));
                end
            end else begin
                chk("idle_enables", 32'({rf_write_en, rf_out_en}), 32'd0);
            end
            if (rvalid != 3'b000) begin
                if (rq.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("rvalid_vec",   32'(rvalid), 32'(1) << r.idx);
                    chk("rvalid_cycle", 32'(cyc), 32'(r.c));
                    chk("rdata",        32'(rdata), 32'(r.d));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setr(input int i, input bit w, input logic [2:0] s, input logic [7:0] d);
        we[i]          = w;
        sel[3*i +: 3]  = s;
        wdata[8*i +: 8] = d;
    endtask

    task automatic pg(input int c, input int i, input bit w, input logic [2:0] s, input logic [7:0] d);
        gq.push_back('{c, i, w, s, d});
    endtask

    task automatic pr(input int c, input int i, input logic [7:0] d);
        rq.push_back('{c, i, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt",    32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata",  32'(rdata), 32'd0);
        chk("rst_we",     32'(rf_write_en), 32'd0);
        chk("rst_oe",     32'(rf_out_en), 32'd0);
        chk("rst_sel",    32'(rf_sel), 32'd0);
        chk("rst_din",    32'(rf_data_in), 32'd0);
        req = '0;
`ifdef RF_ARB_LOCK_EN
        lock = '0;
`endif
        step(2);
        rst_n = 1'b1;
    endtask

    int b;

    initial begin
        #2;
        do_reset();

        // Single write, then single read of the same register.
        b = cyc; setr(0, 1'b1, 3'd2, 8'hA5); req = 3'b001;
        pg(b + 1, 0, 1'b1, 3'd2, 8'hA5);
        step(1); req = '0; step(3);
        b = cyc; setr(1, 1'b0, 3'd2, 8'h00); req = 3'b010;
        pg(b + 1, 1, 1'b0, 3'd2, 8'h00); pr(b + 2, 1, 8'hA5);
        step(1); req = '0; step(3);

        // Fairness from reset: all three held for six cycles.
        do_reset();
        b = cyc;
        setr(0, 1'b1, 3'd3, 8'h11); setr(1, 1'b1, 3'd4, 8'h22); setr(2, 1'b1, 3'd5, 8'h33);
        req = 3'b111;
        for (int k = 0; k < 6; k++)
            pg(b + 1 + k, k % 3, 1'b1, 3'(3 + k % 3), 8'(8'h11 * (k % 3 + 1)));
        step(6); req = '0; step(3);

        // Withdraw: requester 1 pulses alongside requester 0 and must never be granted.
        do_reset();
        b = cyc; setr(0, 1'b0, 3'd3, 8'h00); setr(1, 1'b1, 3'd7, 8'hEE); req = 3'b011;
        pg(b + 1, 0, 1'b0, 3'd3, 8'h00); pr(b + 2, 0, 8'h11);
        step(1); req = '0; step(4);
        chk("withdraw_no_write", 32'(mem[7]), 32'd0);

        // Read followed by write: rvalid of the read coincides with the write grant.
        b = cyc; setr(1, 1'b0, 3'd5, 8'h00); setr(0, 1'b1, 3'd6, 8'h5A); req = 3'b011;
        pg(b + 1, 1, 1'b0, 3'd5, 8'h00); pr(b + 2, 1, 8'h33);
        pg(b + 2, 0, 1'b1, 3'd6, 8'h5A);
        step(1); req = 3'b001; step(1); req = '0; step(3);
        b = cyc; setr(2, 1'b0, 3'd6, 8'h00); req = 3'b100;
        pg(b + 1, 2, 1'b0, 3'd6, 8'h00); pr(b + 2, 2, 8'h5A);
        step(1); req = '0; step(3);

        // Reset in the middle of a read grant.
        b = cyc; setr(2, 1'b0, 3'd4, 8'h00); req = 3'b100;
        pg(b + 1, 2, 1'b0, 3'd4, 8'h00);
        step(1); req = '0;
        @(negedge clk); #1;
        do_reset();
        step(4);
        chk("rvalid_after_reset", 32'(rvalid), 32'd0);

`ifdef RF_ARB_LOCK_EN
        // Lock: 16 consecutive grants to 2, then round-robin lets 0 in, then 2 resumes.
        do_reset();
        b = cyc; setr(2, 1'b1, 3'd7, 8'h77); setr(0, 1'b1, 3'd0, 8'h01);
        req = 3'b100; lock = 3'b100;
        for (int k = 1; k <= 16; k++) pg(b + k, 2, 1'b1, 3'd7, 8'h77);
        pg(b + 17, 0, 1'b1, 3'd0, 8'h01);
        for (int k = 18; k <= 20; k++) pg(b + k, 2, 1'b1, 3'd7, 8'h77);
        step(1); req = 3'b101;
        step(16); req = 3'b100;
        step(3); req = '0; lock = '0;
        step(3);
`endif

        step(2);
        chk("grant_queue_drained",  32'(gq.size()), 32'd0);
        chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
